char_addr_gen: RTL and testbench
================================

# char_addr_gen

Multi-slot, scalable successor to the single-character glyph address generator in the myVGA character display path. It holds `NUM_SLOTS` programmable character slots, each with its own code, position, scale and enable. For every incoming pixel coordinate it finds the lowest-index enabled slot covering that pixel. It then emits the glyph ROM row address and the column bit select through a 2-stage registered pipeline, which feeds the font ROM and the pixel mux.

## Interface
Parameters:
- `NUM_SLOTS`, 8: number of character slots; must be ≥ 1.
- `CNT_W`, 12: width of `hcnt`/`vcnt` and slot coordinates.
- `ASCII_W`, 7: character code width.
- `GLYPH_W`, 8: glyph width in pixels; must be a power of two.
- `GLYPH_H`, 16: glyph height in pixels; must be a power of two.
- `ROW_FLIP`, 1: 1 means the ROM stores rows bottom-up, so `row_out = GLYPH_H-1-row`.
- `SCALE_W`, 2: width of the scale code; magnification is `2^scale` (1×..8× by default).

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `pix_valid`, in, 1: `hcnt`/`vcnt` is valid this cycle.
- `hcnt`, in, `CNT_W`: pixel column.
- `vcnt`, in, `CNT_W`: pixel row.
- `wr_en`, in, 1: slot write strobe.
- `wr_slot`, in, `clog2(NUM_SLOTS)`: slot index to write. Indices ≥ `NUM_SLOTS` are ignored.
- `wr_ascii`, in, `ASCII_W`: character code.
- `wr_x`, in, `CNT_W`: left edge of the character.
- `wr_y`, in, `CNT_W`: top edge of the character.
- `wr_scale`, in, `SCALE_W`: scale exponent.
- `wr_on`, in, 1: slot enable.
- `out_valid`, out, 1: `pix_valid` delayed by 2 cycles.
- `hit`, out, 1: the pixel lies inside an enabled slot.
- `hit_slot`, out, `clog2(NUM_SLOTS)`: index of the winning slot.
- `addr`, out, `ASCII_W+clog2(GLYPH_H)`: `{ascii, row_out}` (11 bits by default).
- `col`, out, `clog2(GLYPH_W)`: bit select within the glyph row; 0 = leftmost pixel.

## Operation
- Slot file: `NUM_SLOTS` registers of {ascii, x, y, scale, on}.
  - Written on a `clk` edge when `wr_en` is high.
  - A write is visible to lookups presented on the following cycle. A lookup presented in the same cycle as a write to the same slot uses the old contents.
- Per slot, computed in `CNT_W+SCALE_W+4` bits so nothing wraps:
  - `dx = hcnt - x`, `dy = vcnt - y`.
  - Match when `on`, `hcnt ≥ x`, `vcnt ≥ y`, `dx < GLYPH_W<<scale` and `dy < GLYPH_H<<scale`.
- A character extending past `2^CNT_W - 1` is clipped. Wrap-around never produces a hit at small coordinates.
- Priority: the lowest matching index wins. Overlapping slots never merge.
- Hit outputs: `row = dy >> scale`, `col = dx >> scale`, then `row_out` is `row` or `GLYPH_H-1-row` according to `ROW_FLIP`.
- Miss, or `out_valid = 0`: `hit = 0`, `hit_slot = 0`, `addr = 0`, `col = 0`.
- The pipeline never stalls. `pix_valid = 0` inserts a bubble.

## Timing
- Stage 1 registers the per-slot match vector plus `dx`/`dy` for every slot.
- Stage 2 registers the priority select, the shifts and the row flip into the outputs.
- Latency is exactly 2 cycles from `pix_valid`/`hcnt`/`vcnt` to `out_valid` and the data outputs. Throughput is one pixel per clock.
- Reset:
  - On the first edge with `rst = 1`, all slot `on` bits, ascii, x, y and scale clear to 0, and both pipeline valid bits clear.
  - All outputs read 0 from the following cycle and remain 0 until `pix_valid` arrives two cycles after `rst` deasserts.
  - In-flight pixels are discarded.
- `wr_en` together with `rst`: reset wins and the write is dropped.

## Structure
- Package `char_gen_pkg`:
  - `slot_t` struct {ascii, x, y, scale, on}.
  - Derived `ROW_W`, `COL_W` and `IDX_W` functions/localparams.
  - Default glyph dimensions.
- Sub-module `char_slot_match`: combinational per-slot match plus `dx`/`dy`, instantiated `NUM_SLOTS` times.
- The top level holds the slot file, both pipeline stages and the priority encoder.

## Test plan
- Basic lookup: slot 0 = {0x41, x=100, y=200, scale 0, on}; pixel (103, 205). Two cycles later expect `hit=1`, `hit_slot=0`, `addr=0x41A`, `col=3`.
- Scale: slot 1 = {0x42, x=300, y=50, scale 1, on}.
  - Pixel (315, 81) → `col=7`, `addr=0x420`.
  - Pixel (316, 81) → `hit=0`, `addr=0`.
- Overlap: slots 2 and 5 both cover (10, 10) → `hit_slot=2`. Then set slot 2 `on=0` → `hit_slot=5`.
- Write collision: write slot 0 `x=500` in the same cycle that pixel (103, 205) is presented → hit with the old data. The same pixel one cycle later → miss.
- Edge clip: slot 3 at x=4090, scale 0.
  - `hcnt=4095` → `col=5`, hit.
  - `hcnt=0..1` with a matching `vcnt` → miss.
- Reset mid-stream: assert `rst` for 1 cycle during continuous `pix_valid`.
  - Outputs read 0 from the next cycle.
  - All slots miss afterwards until rewritten.
  - `out_valid` returns exactly 2 cycles after `rst` falls.

Source files
------------

// File: rtl/char_gen_pkg.sv
// Shared types and width helpers for the multi-slot character address generator.
package char_gen_pkg;

  localparam int unsigned DEF_CNT_W   = 12;
  localparam int unsigned DEF_ASCII_W = 7;
  localparam int unsigned DEF_SCALE_W = 2;
  localparam int unsigned DEF_GLYPH_W = 8;
  localparam int unsigned DEF_GLYPH_H = 16;

  // Index width that never collapses to zero bits, so a single-slot build still has ports.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned row_w(input int unsigned glyph_h);
    return idx_w(glyph_h);
  endfunction

  function automatic int unsigned col_w(input int unsigned glyph_w);
    return idx_w(glyph_w);
  endfunction

  // Slot record at the default widths; the top builds the same layout from its parameters.
  typedef struct packed {
    logic [DEF_ASCII_W-1:0] ascii;
    logic [DEF_CNT_W-1:0]   x;
    logic [DEF_CNT_W-1:0]   y;
    logic [DEF_SCALE_W-1:0] scale;
    logic                   on;
  } slot_t;

endpackage

// File: rtl/char_slot_match.sv
// Combinational coverage test of one character slot against a pixel coordinate.
module char_slot_match #(
  parameter int unsigned CNT_W   = 12,
  parameter int unsigned SCALE_W = 2,
  parameter int unsigned GLYPH_W = 8,
  parameter int unsigned GLYPH_H = 16
) (
  input  logic [CNT_W-1:0]   hcnt,
  input  logic [CNT_W-1:0]   vcnt,
  input  logic [CNT_W-1:0]   x,
  input  logic [CNT_W-1:0]   y,
  input  logic [SCALE_W-1:0] scale,
  input  logic               on,
  output logic               match,
  output logic [CNT_W-1:0]   dx,
  output logic [CNT_W-1:0]   dy
);

  // Wide enough that neither the offsets nor the scaled glyph extent can wrap.
  localparam int unsigned EXT_W = CNT_W + SCALE_W + 4;

  logic [EXT_W-1:0] dx_ext, dy_ext, w_lim, h_lim;

  always_comb begin
    dx_ext = EXT_W'(hcnt) - EXT_W'(x);
    dy_ext = EXT_W'(vcnt) - EXT_W'(y);
    w_lim  = EXT_W'(GLYPH_W) << scale;
    h_lim  = EXT_W'(GLYPH_H) << scale;
    match  = on && (hcnt >= x) && (vcnt >= y) && (dx_ext < w_lim) && (dy_ext < h_lim);
    dx     = dx_ext[CNT_W-1:0];
    dy     = dy_ext[CNT_W-1:0];
  end

endmodule

// File: rtl/char_addr_gen.sv
// Multi-slot glyph ROM address generator: slot file, per-slot match stage, priority/output stage.
module char_addr_gen
  import char_gen_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = 8,
  parameter int unsigned CNT_W     = DEF_CNT_W,
  parameter int unsigned ASCII_W   = DEF_ASCII_W,
  parameter int unsigned GLYPH_W   = DEF_GLYPH_W,
  parameter int unsigned GLYPH_H   = DEF_GLYPH_H,
  parameter bit          ROW_FLIP  = 1'b1,
  parameter int unsigned SCALE_W   = DEF_SCALE_W,
  localparam int unsigned IDX_W    = idx_w(NUM_SLOTS),
  localparam int unsigned ROW_W    = row_w(GLYPH_H),
  localparam int unsigned COL_W    = col_w(GLYPH_W)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pix_valid,
  input  logic [CNT_W-1:0]         hcnt,
  input  logic [CNT_W-1:0]         vcnt,
  input  logic                     wr_en,
  input  logic [IDX_W-1:0]         wr_slot,
  input  logic [ASCII_W-1:0]       wr_ascii,
  input  logic [CNT_W-1:0]         wr_x,
  input  logic [CNT_W-1:0]         wr_y,
  input  logic [SCALE_W-1:0]       wr_scale,
  input  logic                     wr_on,
  output logic                     out_valid,
  output logic                     hit,
  output logic [IDX_W-1:0]         hit_slot,
  output logic [ASCII_W+ROW_W-1:0] addr,
  output logic [COL_W-1:0]         col
);

  typedef struct packed {
    logic [ASCII_W-1:0] ascii;
    logic [CNT_W-1:0]   x;
    logic [CNT_W-1:0]   y;
    logic [SCALE_W-1:0] scale;
    logic               on;
  } slot_rec_t;

  slot_rec_t            slots_q [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] match_c, match_q;
  logic [CNT_W-1:0]     dx_c [NUM_SLOTS];
  logic [CNT_W-1:0]     dy_c [NUM_SLOTS];
  logic [CNT_W-1:0]     dx_q [NUM_SLOTS];
  logic [CNT_W-1:0]     dy_q [NUM_SLOTS];
  logic [ASCII_W-1:0]   ascii_q [NUM_SLOTS];
  logic [SCALE_W-1:0]   scale_q [NUM_SLOTS];
  logic                 v1_q;

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_match
    char_slot_match #(
      .CNT_W  (CNT_W),
      .SCALE_W(SCALE_W),
      .GLYPH_W(GLYPH_W),
      .GLYPH_H(GLYPH_H)
    ) u_match (
      .hcnt (hcnt),
      .vcnt (vcnt),
      .x    (slots_q[g].x),
      .y    (slots_q[g].y),
      .scale(slots_q[g].scale),
      .on   (slots_q[g].on),
      .match(match_c[g]),
      .dx   (dx_c[g]),
      .dy   (dy_c[g])
    );
  end

  logic               sel_hit;
  logic [IDX_W-1:0]   sel_idx;
  logic [ROW_W-1:0]   row_c;
  logic [COL_W-1:0]   col_c;

  // Stage 2 priority: scanning downwards leaves the lowest matching index selected.
  always_comb begin
    sel_hit = 1'b0;
    sel_idx = '0;
    for (int i = int'(NUM_SLOTS) - 1; i >= 0; i--) begin
      if (match_q[i]) begin
        sel_hit = 1'b1;
        sel_idx = IDX_W'(i);
      end
    end
    col_c = COL_W'(dx_q[sel_idx] >> scale_q[sel_idx]);
    row_c = ROW_W'(dy_q[sel_idx] >> scale_q[sel_idx]);
    if (ROW_FLIP) row_c = ROW_W'(GLYPH_H - 1) - row_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
        slots_q[i] <= '0;
        dx_q[i]    <= '0;
        dy_q[i]    <= '0;
        ascii_q[i] <= '0;
        scale_q[i] <= '0;
      end
      match_q   <= '0;
      v1_q      <= 1'b0;
      out_valid <= 1'b0;
      hit       <= 1'b0;
      hit_slot  <= '0;
      addr      <= '0;
      col       <= '0;
    end else begin
      if (wr_en && (32'(wr_slot) < NUM_SLOTS)) begin
        slots_q[wr_slot] <= '{ascii: wr_ascii, x: wr_x, y: wr_y, scale: wr_scale, on: wr_on};
      end
      // Stage 1 snapshots ascii/scale so a later write cannot tear an in-flight pixel.
      v1_q    <= pix_valid;
      match_q <= pix_valid ? match_c : '0;
      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
        dx_q[i]    <= dx_c[i];
        dy_q[i]    <= dy_c[i];
        ascii_q[i] <= slots_q[i].ascii;
        scale_q[i] <= slots_q[i].scale;
      end
      out_valid <= v1_q;
      if (v1_q && sel_hit) begin
        hit      <= 1'b1;
        hit_slot <= sel_idx;
        addr     <= {ascii_q[sel_idx], row_c};
        col      <= col_c;
      end else begin
        hit      <= 1'b0;
        hit_slot <= '0;
        addr     <= '0;
        col      <= '0;
      end
    end
  end

endmodule

// File: tb/tb_char_addr_gen.sv
// Self-checking bench for char_addr_gen: directed scenarios plus randomized traffic vs a model.
module tb_char_addr_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_valid;
  logic [11:0] hcnt, vcnt;
  logic        wr_en;
  logic [2:0]  wr_slot;
  logic [6:0]  wr_ascii;
  logic [11:0] wr_x, wr_y;
  logic [1:0]  wr_scale;
  logic        wr_on;
  logic        out_valid, hit;
  logic [2:0]  hit_slot;
  logic [10:0] addr;
  logic [2:0]  col;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  char_addr_gen dut (
    .clk      (clk),
    .rst      (rst),
    .pix_valid(pix_valid),
    .hcnt     (hcnt),
    .vcnt     (vcnt),
    .wr_en    (wr_en),
    .wr_slot  (wr_slot),
    .wr_ascii (wr_ascii),
    .wr_x     (wr_x),
    .wr_y     (wr_y),
    .wr_scale (wr_scale),
    .wr_on    (wr_on),
    .out_valid(out_valid),
    .hit      (hit),
    .hit_slot (hit_slot),
    .addr     (addr),
    .col      (col)
  );

  typedef struct packed {
    logic        v;
    logic        hit;
    logic [2:0]  slot;
    logic [10:0] addr;
    logic [2:0]  col;
  } exp_t;

  // Reference slot contents as plain integers.
  int   m_ascii [8];
  int   m_x     [8];
  int   m_y     [8];
  int   m_sc    [8];
  int   m_on    [8];
  exp_t e1, eo;
  bit   checking = 1'b0;

  function automatic exp_t lookup(input int h, input int v);
    exp_t r;
    r = '0;
    r.v = 1'b1;
    for (int i = 0; i < 8; i++) begin
      int dxv, dyv;
      dxv = h - m_x[i];
      dyv = v - m_y[i];
      if (m_on[i] != 0 && dxv >= 0 && dyv >= 0 && dxv < (8 << m_sc[i]) &&
          dyv < (16 << m_sc[i])) begin
        r.hit  = 1'b1;
        r.slot = 3'(i);
        r.col  = 3'(dxv >> m_sc[i]);
        r.addr = 11'(m_ascii[i] * 16 + (15 - (dyv >> m_sc[i])));
        return r;
      end
    end
    return r;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    if (rst) begin
      e1 <= '0;
      eo <= '0;
      for (int i = 0; i < 8; i++) begin
        m_ascii[i] <= 0;
        m_x[i]     <= 0;
        m_y[i]     <= 0;
        m_sc[i]    <= 0;
        m_on[i]    <= 0;
      end
      checking <= 1'b1;
    end else begin
      e  = pix_valid ? lookup(int'(hcnt), int'(vcnt)) : '0;
      e1 <= e;
      eo <= e1;
      if (wr_en) begin
        m_ascii[wr_slot] <= int'(wr_ascii);
        m_x[wr_slot]     <= int'(wr_x);
        m_y[wr_slot]     <= int'(wr_y);
        m_sc[wr_slot]    <= int'(wr_scale);
        m_on[wr_slot]    <= int'(wr_on);
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      checks++;
      if ({out_valid, hit, hit_slot, addr, col} !== eo) begin
        errors++;
        $display("FAIL pipe_cmp t=%0t: got v=%b hit=%b slot=%0d addr=%h col=%0d, want v=%b hit=%b slot=%0d addr=%h col=%0d",
                 $time, out_valid, hit, hit_slot, addr, col, eo.v, eo.hit, eo.slot, eo.addr,
                 eo.col);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_write(input int s, input int a, input int x, input int y, input int sc,
                          input int on);
    tick();
    pix_valid = 1'b0;
    wr_en     = 1'b1;
    wr_slot   = 3'(s);
    wr_ascii  = 7'(a);
    wr_x      = 12'(x);
    wr_y      = 12'(y);
    wr_scale  = 2'(sc);
    wr_on     = 1'(on);
    tick();
    wr_en = 1'b0;
  endtask

  // Present one pixel; on return the outputs belong to it.
  task automatic do_pix(input int h, input int v);
    tick();
    pix_valid = 1'b1;
    hcnt      = 12'(h);
    vcnt      = 12'(v);
    tick();
    pix_valid = 1'b0;
    tick();
  endtask

  task automatic expect_out(input string name, input int ov, input int h, input int s,
                            input int a, input int c);
    checks++;
    if (out_valid !== 1'(ov) || hit !== 1'(h) || hit_slot !== 3'(s) || addr !== 11'(a) ||
        col !== 3'(c)) begin
      errors++;
      $display("FAIL %s: got v=%b hit=%b slot=%0d addr=%h col=%0d, want v=%0d hit=%0d slot=%0d addr=%h col=%0d",
               name, out_valid, hit, hit_slot, addr, col, ov, h, s, a, c);
    end
  endtask

  initial begin
    rst = 1'b1; pix_valid = 1'b0; hcnt = '0; vcnt = '0;
    wr_en = 1'b0; wr_slot = '0; wr_ascii = '0; wr_x = '0; wr_y = '0; wr_scale = '0; wr_on = 1'b0;
    tick(); tick();
    rst = 1'b0;
    expect_out("reset_state", 0, 0, 0, 0, 0);

    do_write(0, 'h41, 100, 200, 0, 1);
    do_pix(103, 205);
    expect_out("basic", 1, 1, 0, 'h41A, 3);

    do_write(1, 'h42, 300, 50, 1, 1);
    do_pix(315, 81);
    expect_out("scale_in", 1, 1, 1, 'h420, 7);
    do_pix(316, 81);
    expect_out("scale_out", 1, 0, 0, 0, 0);

    do_write(2, 'h32, 8, 8, 0, 1);
    do_write(5, 'h35, 0, 0, 2, 1);
    do_pix(10, 10);
    expect_out("overlap_lo", 1, 1, 2, 'h32D, 2);
    do_write(2, 'h32, 8, 8, 0, 0);
    do_pix(10, 10);
    expect_out("overlap_hi", 1, 1, 5, 'h35D, 2);

    // Write and lookup of the same slot in one cycle.
    tick();
    wr_en = 1'b1; wr_slot = 3'd0; wr_ascii = 7'h41; wr_x = 12'd500; wr_y = 12'd200;
    wr_scale = 2'd0; wr_on = 1'b1;
    pix_valid = 1'b1; hcnt = 12'd103; vcnt = 12'd205;
    tick();
    wr_en = 1'b0;
    tick();
    pix_valid = 1'b0;
    expect_out("collide_old", 1, 1, 0, 'h41A, 3);
    tick();
    expect_out("collide_new", 1, 0, 0, 0, 0);

    do_write(3, 'h33, 4090, 1000, 0, 1);
    do_pix(4095, 1000);
    expect_out("clip_hit", 1, 1, 3, 'h33F, 5);
    do_pix(0, 1000);
    expect_out("clip_wrap0", 1, 0, 0, 0, 0);
    do_pix(1, 1000);
    expect_out("clip_wrap1", 1, 0, 0, 0, 0);
    tick();
    expect_out("bubble", 0, 0, 0, 0, 0);

    // One-cycle reset during continuous pixel traffic.
    tick();
    pix_valid = 1'b1; hcnt = 12'd10; vcnt = 12'd10;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_out("rst_clear", 0, 0, 0, 0, 0);
    tick();
    expect_out("rst_lat1", 0, 0, 0, 0, 0);
    tick();
    expect_out("rst_lat2", 1, 0, 0, 0, 0);
    pix_valid = 1'b0;
    do_pix(103, 205);
    expect_out("post_rst_miss", 1, 0, 0, 0, 0);
    do_pix(0, 0);
    expect_out("post_rst_zero", 1, 0, 0, 0, 0);

    // Randomized traffic aimed at and around the programmed slots.
    for (int n = 0; n < 4000; n++) begin
      int s;
      tick();
      rst      = ($urandom % 300 == 0);
      wr_en    = ($urandom % 5 == 0);
      wr_slot  = 3'($urandom);
      wr_ascii = 7'($urandom);
      wr_x     = ($urandom % 4 == 0) ? 12'(4095 - $urandom % 24) : 12'($urandom % 4096);
      wr_y     = ($urandom % 4 == 0) ? 12'(4095 - $urandom % 80) : 12'($urandom % 4096);
      wr_scale = 2'($urandom);
      wr_on    = ($urandom % 4 != 0);
      pix_valid = ($urandom % 8 != 0);
      s    = int'($urandom % 8);
      hcnt = 12'(m_x[s] + int'($urandom % 72) - 4);
      vcnt = 12'(m_y[s] + int'($urandom % 140) - 4);
    end
    tick();
    rst = 1'b0; wr_en = 1'b0; pix_valid = 1'b0;
    tick(); tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
